// File: rtl/conv_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the configurable 3x3 convolution block:
//   - filter mode encodings and the helper that folds the reserved mode
//   - window geometry (tap count, centre tap index)
//   - coefficient-bank address of the normalisation shift register
//   - default R/G/B channel widths of the packed pixel
// ---------------------------------------------------------------------------
package conv_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS   = 2'd0,
    MODE_BOX      = 2'd1,
    MODE_CUSTOM   = 2'd2,
    MODE_RESERVED = 2'd3
  } conv_mode_e;

  localparam int NUM_TAPS   = 9;
  localparam int CENTRE_TAP = 4;

  localparam logic [3:0] SHIFT_ADDR = 4'd9;

  localparam int DEF_R_W = 3;
  localparam int DEF_G_W = 3;
  localparam int DEF_B_W = 2;

  // The reserved encoding behaves exactly like bypass, so it is folded once
  // on entry and the rest of the pipeline only ever sees three modes.
  function automatic conv_mode_e normaliseMode(input logic [1:0] rawMode);
    if (rawMode == MODE_RESERVED) begin
      return MODE_BYPASS;
    end
    return conv_mode_e'(rawMode);
  endfunction

endpackage

// File: rtl/conv_coeff_bank.sv
// ---------------------------------------------------------------------------
// conv_coeff_bank
// Shadow and active kernel registers for the custom convolution mode.
// Software writes taps/shift into the shadow set at any time; a commit marks
// the shadow set pending, and the copy into the active set waits until the
// datapath is completely empty so no window ever sees a mixed kernel.
//
// Ports:
//   clock_i          clock
//   reset_i          synchronous active-high reset (restores identity kernel)
//   coeffWr_i        write strobe for the shadow register at coeffAddr_i
//   coeffAddr_i      0-8 tap index, 9 shift, 10-15 ignored
//   coeffData_i      signed tap value, or shift in the low SHIFT_W bits
//   coeffCommit_i    request to copy shadow -> active
//   pipeIdle_i       no valid window in any stage and none arriving
//   activeCoeff_o    active taps, tap k at [COEFF_W*k +: COEFF_W]
//   activeShift_o    active normalisation shift
//   commitPending_o  a commit is waiting for the pipeline to drain
// ---------------------------------------------------------------------------
module conv_coeff_bank
  import conv_pkg::*;
#(
  parameter int COEFF_W = 8,
  parameter int SHIFT_W = 4
) (
  input  logic                          clock_i,
  input  logic                          reset_i,
  input  logic                          coeffWr_i,
  input  logic [3:0]                    coeffAddr_i,
  input  logic [COEFF_W-1:0]            coeffData_i,
  input  logic                          coeffCommit_i,
  input  logic                          pipeIdle_i,
  output logic [NUM_TAPS*COEFF_W-1:0]   activeCoeff_o,
  output logic [SHIFT_W-1:0]            activeShift_o,
  output logic                          commitPending_o
);

  logic [COEFF_W-1:0] shadowCoeff_q [NUM_TAPS];
  logic [COEFF_W-1:0] shadowCoeff_d [NUM_TAPS];
  logic [COEFF_W-1:0] activeCoeff_q [NUM_TAPS];
  logic [SHIFT_W-1:0] shadowShift_q;
  logic [SHIFT_W-1:0] shadowShift_d;
  logic [SHIFT_W-1:0] activeShift_q;
  logic               pending_q;
  logic               pending_d;
  logic               copyNow;

  // Next shadow contents: the write lands here first, so a copy happening in
  // the same cycle (or a commit issued alongside the write) already sees it.
  always_comb begin
    shadowCoeff_d = shadowCoeff_q;
    shadowShift_d = shadowShift_q;
    if (coeffWr_i) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        if (coeffAddr_i == 4'(k)) begin
          shadowCoeff_d[k] = coeffData_i;
        end
      end
      if (coeffAddr_i == SHIFT_ADDR) begin
        shadowShift_d = coeffData_i[SHIFT_W-1:0];
      end
    end
  end

  // The copy only fires on a cycle where the datapath is empty. A commit that
  // arrives while one is already pending adds nothing, and the flag drops on
  // the very edge that performs the copy.
  always_comb begin
    copyNow   = pending_q && pipeIdle_i;
    pending_d = copyNow ? 1'b0 : (pending_q | coeffCommit_i);
  end

  // Register bank; reset restores the identity kernel (centre tap 1, shift 0)
  // in both sets and overrides any write or commit in the same cycle.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        shadowCoeff_q[k] <= (k == CENTRE_TAP) ? COEFF_W'(1) : '0;
        activeCoeff_q[k] <= (k == CENTRE_TAP) ? COEFF_W'(1) : '0;
      end
      shadowShift_q <= '0;
      activeShift_q <= '0;
      pending_q     <= 1'b0;
    end else begin
      shadowCoeff_q <= shadowCoeff_d;
      shadowShift_q <= shadowShift_d;
      pending_q     <= pending_d;
      if (copyNow) begin
        activeCoeff_q <= shadowCoeff_d;
        activeShift_q <= shadowShift_d;
      end
    end
  end

  // Flatten the active taps for the datapath.
  always_comb begin
    for (int k = 0; k < NUM_TAPS; k++) begin
      activeCoeff_o[k*COEFF_W +: COEFF_W] = activeCoeff_q[k];
    end
  end

  assign activeShift_o   = activeShift_q;
  assign commitPending_o = pending_q;

endmodule

// File: rtl/configurable_convolution.sv
// ---------------------------------------------------------------------------
// configurable_convolution
// Four-stage, fully pipelined 3x3 filter over packed RGB pixels:
//   stage 1  unpack each channel (right-aligned, zero-extended), fold mode
//   stage 2  per-tap products (kernel coefficient, or 1 for box blur)
//   stage 3  per-channel signed sum of the nine products
//   stage 4  normalise (divide by 9 or arithmetic shift), clamp, pack
// One window is accepted per cycle; valid-in to valid-out is 4 cycles.
//
// Ports:
//   i_clock, i_reset             clock, synchronous active-high reset
//   i_pixel_data                 3x3 window, tap k at [PIX_W*k +: PIX_W],
//                                row-major, tap 4 is the centre
//   i_pixel_data_valid           window strobe
//   i_mode                       0 bypass, 1 box blur, 2 custom, 3 = bypass
//   i_coeff_wr/addr/data         shadow kernel write port
//   i_coeff_commit               request shadow -> active copy
//   o_convoled_pixel(_valid)     filtered pixel, held while valid is low
//   o_commit_pending             commit waiting for the pipeline to drain
// ---------------------------------------------------------------------------
module configurable_convolution
  import conv_pkg::*;
#(
  parameter int PIX_W   = 8,
  parameter int R_W     = DEF_R_W,
  parameter int G_W     = DEF_G_W,
  parameter int B_W     = DEF_B_W,
  parameter int COEFF_W = 8,
  parameter int SHIFT_W = 4
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic [NUM_TAPS*PIX_W-1:0]   i_pixel_data,
  input  logic                        i_pixel_data_valid,
  input  logic [1:0]                  i_mode,
  input  logic                        i_coeff_wr,
  input  logic [3:0]                  i_coeff_addr,
  input  logic [COEFF_W-1:0]          i_coeff_data,
  input  logic                        i_coeff_commit,
  output logic [PIX_W-1:0]            o_convoled_pixel,
  output logic                        o_convoled_pixel_valid,
  output logic                        o_commit_pending
);

  logic [NUM_TAPS*COEFF_W-1:0] activeCoeff;
  logic [SHIFT_W-1:0]          activeShift;
  logic                        pipeIdle;

  logic                        validS1_q, validS2_q, validS3_q, outValid_q;
  conv_mode_e                  modeS1_q, modeS2_q, modeS3_q;
  logic [PIX_W-1:0]            centreS1_q, centreS2_q, centreS3_q;
  logic [PIX_W-1:0]            outPixel_q;
  logic [PIX_W-1:0]            nextPixel;

  // A kernel swap is only safe when nothing is in flight and nothing is about
  // to enter, which guarantees every window sees a single consistent set.
  assign pipeIdle = !validS1_q && !validS2_q && !validS3_q && !outValid_q
                    && !i_pixel_data_valid;

  conv_coeff_bank #(
    .COEFF_W (COEFF_W),
    .SHIFT_W (SHIFT_W)
  ) uCoeffBank (
    .clock_i         (i_clock),
    .reset_i         (i_reset),
    .coeffWr_i       (i_coeff_wr),
    .coeffAddr_i     (i_coeff_addr),
    .coeffData_i     (i_coeff_data),
    .coeffCommit_i   (i_coeff_commit),
    .pipeIdle_i      (pipeIdle),
    .activeCoeff_o   (activeCoeff),
    .activeShift_o   (activeShift),
    .commitPending_o (o_commit_pending)
  );

  // Control pipeline: valid, mode and the untouched centre pixel travel with
  // the window. Reset drops everything in flight. The output register only
  // loads on a valid window so the last result is held between windows.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      validS1_q  <= 1'b0;
      validS2_q  <= 1'b0;
      validS3_q  <= 1'b0;
      outValid_q <= 1'b0;
      outPixel_q <= '0;
      modeS1_q   <= MODE_BYPASS;
      modeS2_q   <= MODE_BYPASS;
      modeS3_q   <= MODE_BYPASS;
    end else begin
      validS1_q  <= i_pixel_data_valid;
      validS2_q  <= validS1_q;
      validS3_q  <= validS2_q;
      outValid_q <= validS3_q;
      modeS1_q   <= normaliseMode(i_mode);
      modeS2_q   <= modeS1_q;
      modeS3_q   <= modeS2_q;
      centreS1_q <= i_pixel_data[CENTRE_TAP*PIX_W +: PIX_W];
      centreS2_q <= centreS1_q;
      centreS3_q <= centreS2_q;
      if (validS3_q) begin
        outPixel_q <= nextPixel;
      end
    end
  end

  // One datapath slice per colour channel, each at its own native width.
  // Channel 0 is red (MSBs), channel 2 is blue (LSBs).
  for (genvar c = 0; c < 3; c++) begin : gChan
    localparam int CW  = (c == 0) ? R_W : ((c == 1) ? G_W : B_W);
    localparam int OFF = (c == 0) ? (G_W + B_W) : ((c == 1) ? B_W : 0);
    localparam int PW  = COEFF_W + CW + 1;
    localparam int SW  = PW + 4;
    localparam logic signed [SW-1:0] CH_MAX = SW'((1 << CW) - 1);

    logic [CW-1:0]        tapS1_q  [NUM_TAPS];
    logic signed [PW-1:0] prodS2_q [NUM_TAPS];
    logic signed [PW-1:0] prodS2_d [NUM_TAPS];
    logic signed [SW-1:0] sumS3_q;
    logic signed [SW-1:0] sumS3_d;
    logic signed [SW-1:0] shifted;
    logic signed [SW-1:0] boxQuot;
    logic [CW-1:0]        chanOut;

    // Products: taps are unsigned so a zero bit is prepended before the signed
    // multiply. Box blur uses an implicit coefficient of one; bypass needs no
    // arithmetic since the centre pixel rides alongside.
    always_comb begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        prodS2_d[k] = '0;
        if (modeS1_q == MODE_BOX) begin
          prodS2_d[k] = PW'(signed'({1'b0, tapS1_q[k]}));
        end else if (modeS1_q == MODE_CUSTOM) begin
          prodS2_d[k] = PW'(signed'(activeCoeff[k*COEFF_W +: COEFF_W]))
                        * PW'(signed'({1'b0, tapS1_q[k]}));
        end
      end
    end

    // Four guard bits on top of the product width cover nine accumulations.
    always_comb begin
      sumS3_d = '0;
      for (int k = 0; k < NUM_TAPS; k++) begin
        sumS3_d = sumS3_d + SW'(prodS2_q[k]);
      end
    end

    // Datapath registers carry no reset; only the valids decide whether
    // their contents matter.
    always_ff @(posedge i_clock) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        tapS1_q[k]  <= i_pixel_data[PIX_W*k + OFF +: CW];
        prodS2_q[k] <= prodS2_d[k];
      end
      sumS3_q <= sumS3_d;
    end

    // Normalisation: box blur is an exact floor divide (the sum is never
    // negative there); the custom kernel uses an arithmetic shift and then
    // clamps to the channel's representable range.
    always_comb begin
      shifted = sumS3_q >>> activeShift;
      boxQuot = sumS3_q / SW'(9);
      chanOut = centreS3_q[OFF +: CW];
      if (modeS3_q == MODE_BOX) begin
        chanOut = CW'(boxQuot);
      end else if (modeS3_q == MODE_CUSTOM) begin
        if (shifted[SW-1]) begin
          chanOut = '0;
        end else if (shifted > CH_MAX) begin
          chanOut = '1;
        end else begin
          chanOut = shifted[CW-1:0];
        end
      end
    end

    assign nextPixel[OFF +: CW] = chanOut;
  end

  assign o_convoled_pixel       = outPixel_q;
  assign o_convoled_pixel_valid = outValid_q;

endmodule

// File: tb/tb_configurable_convolution.sv
// ---------------------------------------------------------------------------
// tb_configurable_convolution
// Drives random and directed 3x3 windows into configurable_convolution and
// compares each output against an integer reference model of the filter
// rules, including kernel commit timing and reset behaviour.
// ---------------------------------------------------------------------------
module tb_configurable_convolution;

  logic        clk;
  logic        rst;
  logic [71:0] pixData;
  logic        pixValid;
  logic [1:0]  mode;
  logic        coeffWr;
  logic [3:0]  coeffAddr;
  logic [7:0]  coeffData;
  logic        coeffCommit;
  logic [7:0]  outPix;
  logic        outValid;
  logic        pending;

  int checks = 0;
  int errors = 0;

  int activeC [9];
  int shadowC [9];
  int activeShift;
  int shadowShift;

  logic [71:0] stimWin  [$];
  logic [1:0]  stimMode [$];
  logic [7:0]  expPix   [$];
  logic [7:0]  obsPix   [$];
  int          obsCyc   [$];
  logic        obsPend  [$];

  configurable_convolution dut (
    .i_clock                (clk),
    .i_reset                (rst),
    .i_pixel_data           (pixData),
    .i_pixel_data_valid     (pixValid),
    .i_mode                 (mode),
    .i_coeff_wr             (coeffWr),
    .i_coeff_addr           (coeffAddr),
    .i_coeff_data           (coeffData),
    .i_coeff_commit         (coeffCommit),
    .o_convoled_pixel       (outPix),
    .o_convoled_pixel_valid (outValid),
    .o_commit_pending       (pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Reference model: each channel of the packed pixel, computed with plain
  // integer arithmetic straight from the filter definitions.
  function automatic logic [7:0] modelPixel(input logic [71:0] win, input logic [1:0] m);
    int wid [3] = '{3, 3, 2};
    int off [3] = '{5, 2, 0};
    logic [7:0] res;
    int sum, v, maxv, tap;
    if (m == 2'd0 || m == 2'd3) return win[39:32];
    res = 8'h00;
    for (int c = 0; c < 3; c++) begin
      maxv = (1 << wid[c]) - 1;
      sum = 0;
      for (int k = 0; k < 9; k++) begin
        tap = int'(win >> (k*8 + off[c])) & maxv;
        sum += (m == 2'd1) ? tap : activeC[k] * tap;
      end
      if (m == 2'd1) v = sum / 9;
      else begin
        v = sum >>> activeShift;
        if (v < 0) v = 0;
        if (v > maxv) v = maxv;
      end
      res = res | 8'(v << off[c]);
    end
    return res;
  endfunction

  function automatic void modelIdentity();
    for (int k = 0; k < 9; k++) begin
      activeC[k] = (k == 4) ? 1 : 0;
      shadowC[k] = (k == 4) ? 1 : 0;
    end
    activeShift = 0;
    shadowShift = 0;
  endfunction

  function automatic logic [71:0] randWindow();
    logic [71:0] w;
    for (int k = 0; k < 9; k++) w[k*8 +: 8] = 8'($urandom);
    return w;
  endfunction

  function automatic void clearStim();
    stimWin.delete();
    stimMode.delete();
    expPix.delete();
  endfunction

  function automatic void addWindow(input logic [71:0] w, input logic [1:0] m);
    stimWin.push_back(w);
    stimMode.push_back(m);
    expPix.push_back(modelPixel(w, m));
  endfunction

  // Drive all queued windows back to back, recording every output pixel with
  // the cycle it appeared and the pending flag each cycle.
  task automatic applyStimulus(input int commitAt);
    obsPix.delete();
    obsCyc.delete();
    obsPend.delete();
    for (int cyc = 0; cyc < stimWin.size() + 12; cyc++) begin
      @(negedge clk);
      obsPend.push_back(pending);
      if (outValid) begin
        obsPix.push_back(outPix);
        obsCyc.push_back(cyc);
      end
      coeffCommit = (cyc == commitAt);
      if (cyc < stimWin.size()) begin
        pixData  = stimWin[cyc];
        mode     = stimMode[cyc];
        pixValid = 1'b1;
      end else begin
        pixValid = 1'b0;
      end
    end
    coeffCommit = 1'b0;
  endtask

  task automatic writeCoeff(input int addr, input logic [7:0] data);
    @(negedge clk);
    coeffWr   = 1'b1;
    coeffAddr = 4'(addr);
    coeffData = data;
    @(negedge clk);
    coeffWr = 1'b0;
    if (addr < 9) shadowC[addr] = int'($signed(data));
    else if (addr == 9) shadowShift = int'(data) & 15;
  endtask

  task automatic commitIdle(output bit sawPending, output bit settled);
    @(negedge clk);
    coeffCommit = 1'b1;
    @(negedge clk);
    coeffCommit = 1'b0;
    sawPending = pending;
    settled = 1'b0;
    for (int i = 0; i < 10 && !settled; i++) begin
      @(negedge clk);
      if (pending === 1'b0) settled = 1'b1;
    end
    activeC = shadowC;
    activeShift = shadowShift;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    coeffWr = 1'b1; coeffAddr = 4'd4; coeffData = 8'h07; coeffCommit = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; coeffWr = 1'b0; coeffCommit = 1'b0;
    modelIdentity();
    @(negedge clk);
    checks++;
    if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got=%b want=0", outValid); end
    checks++;
    if (outPix !== 8'h00) begin errors++; $display("[TB] FAIL reset_pixel got=%h want=00", outPix); end
    checks++;
    if (pending !== 1'b0) begin errors++; $display("[TB] FAIL reset_pending got=%b want=0", pending); end
  endtask

  task automatic test_box_blur();
    logic [71:0] w;
    clearStim();
    addWindow({9{8'hFF}}, 2'd1);
    w = 72'h0; w[39:32] = 8'hE0;
    addWindow(w, 2'd1);
    for (int i = 0; i < 10; i++) addWindow(randWindow(), 2'd1);
    applyStimulus(-1);
    checks++;
    if (obsPix.size() != expPix.size()) begin errors++; $display("[TB] FAIL box_count got=%0d want=%0d", obsPix.size(), expPix.size()); end
    checks++;
    if (obsPix.size() < 2 || obsPix[0] !== 8'hFF || obsPix[1] !== 8'h00) begin
      errors++; $display("[TB] FAIL box_directed got=%h,%h want=ff,00", obsPix[0], obsPix[1]);
    end
    for (int i = 0; i < obsPix.size() && i < expPix.size(); i++) begin
      checks++;
      if (obsPix[i] !== expPix[i] || obsCyc[i] != i + 4) begin
        errors++; $display("[TB] FAIL box_pix[%0d] got=%h@%0d want=%h@%0d", i, obsPix[i], obsCyc[i], expPix[i], i + 4);
      end
    end
    checks++;
    if (outPix !== expPix[expPix.size()-1]) begin errors++; $display("[TB] FAIL box_hold got=%h want=%h", outPix, expPix[expPix.size()-1]); end
  endtask

  task automatic test_bypass();
    logic [71:0] w;
    clearStim();
    w = randWindow(); w[39:32] = 8'h6D;
    addWindow(w, 2'd0);
    addWindow(w, 2'd3);
    for (int i = 0; i < 8; i++) addWindow(randWindow(), 2'($urandom_range(0, 3)));
    applyStimulus(-1);
    checks++;
    if (obsPix.size() < 2 || obsPix[0] !== 8'h6D || obsPix[1] !== 8'h6D) begin
      errors++; $display("[TB] FAIL bypass_directed got=%h,%h want=6d,6d", obsPix[0], obsPix[1]);
    end
    checks++;
    if (obsPix.size() != expPix.size()) begin errors++; $display("[TB] FAIL bypass_count got=%0d want=%0d", obsPix.size(), expPix.size()); end
    for (int i = 0; i < obsPix.size() && i < expPix.size(); i++) begin
      checks++;
      if (obsPix[i] !== expPix[i] || obsCyc[i] != i + 4) begin
        errors++; $display("[TB] FAIL bypass_pix[%0d] got=%h@%0d want=%h@%0d", i, obsPix[i], obsCyc[i], expPix[i], i + 4);
      end
    end
  endtask

  task automatic test_custom_kernel();
    logic [71:0] w;
    bit saw, settled;
    for (int k = 0; k < 9; k++) writeCoeff(k, (k == 4) ? 8'd5 : ((k % 2 == 1) ? 8'hFF : 8'h00));
    writeCoeff(9, 8'h00);
    commitIdle(saw, settled);
    checks++;
    if (saw !== 1'b1 || settled !== 1'b1) begin errors++; $display("[TB] FAIL custom_commit got=%b/%b want=1/1", saw, settled); end
    clearStim();
    addWindow({9{8'h49}}, 2'd2);
    w = 72'h0; w[39:32] = 8'hFF;
    addWindow(w, 2'd2);
    w = {9{8'hFF}}; w[39:32] = 8'h00;
    addWindow(w, 2'd2);
    for (int i = 0; i < 8; i++) addWindow(randWindow(), 2'd2);
    applyStimulus(-1);
    checks++;
    if (obsPix.size() < 3 || obsPix[0] !== 8'h49 || obsPix[1] !== 8'hFF || obsPix[2] !== 8'h00) begin
      errors++; $display("[TB] FAIL custom_directed got=%h,%h,%h want=49,ff,00", obsPix[0], obsPix[1], obsPix[2]);
    end
    checks++;
    if (obsPix.size() != expPix.size()) begin errors++; $display("[TB] FAIL custom_count got=%0d want=%0d", obsPix.size(), expPix.size()); end
    for (int i = 0; i < obsPix.size() && i < expPix.size(); i++) begin
      checks++;
      if (obsPix[i] !== expPix[i] || obsCyc[i] != i + 4) begin
        errors++; $display("[TB] FAIL custom_pix[%0d] got=%h@%0d want=%h@%0d", i, obsPix[i], obsCyc[i], expPix[i], i + 4);
      end
    end
  endtask

  task automatic test_random_custom();
    bit saw, settled;
    for (int k = 0; k < 9; k++) writeCoeff(k, 8'($urandom));
    writeCoeff(9, 8'($urandom_range(0, 15)));
    commitIdle(saw, settled);
    checks++;
    if (saw !== 1'b1 || settled !== 1'b1) begin errors++; $display("[TB] FAIL rand_commit got=%b/%b want=1/1", saw, settled); end
    clearStim();
    for (int i = 0; i < 24; i++) addWindow(randWindow(), 2'($urandom_range(0, 3)));
    applyStimulus(-1);
    checks++;
    if (obsPix.size() != expPix.size()) begin errors++; $display("[TB] FAIL rand_count got=%0d want=%0d", obsPix.size(), expPix.size()); end
    for (int i = 0; i < obsPix.size() && i < expPix.size(); i++) begin
      checks++;
      if (obsPix[i] !== expPix[i] || obsCyc[i] != i + 4) begin
        errors++; $display("[TB] FAIL rand_pix[%0d] got=%h@%0d want=%h@%0d", i, obsPix[i], obsCyc[i], expPix[i], i + 4);
      end
    end
  endtask

  task automatic test_address_ignore();
    bit saw, settled;
    for (int k = 0; k < 9; k++) writeCoeff(k, (k == 4) ? 8'd8 : 8'd0);
    writeCoeff(9, 8'hF3);
    for (int a = 10; a < 16; a++) writeCoeff(a, 8'($urandom_range(1, 127)));
    commitIdle(saw, settled);
    checks++;
    if (saw !== 1'b1 || settled !== 1'b1) begin errors++; $display("[TB] FAIL addr_commit got=%b/%b want=1/1", saw, settled); end
    clearStim();
    for (int i = 0; i < 10; i++) addWindow(randWindow(), 2'd2);
    applyStimulus(-1);
    checks++;
    if (obsPix.size() != expPix.size()) begin errors++; $display("[TB] FAIL addr_count got=%0d want=%0d", obsPix.size(), expPix.size()); end
    for (int i = 0; i < obsPix.size() && i < expPix.size(); i++) begin
      checks++;
      if (obsPix[i] !== stimWin[i][39:32] || obsPix[i] !== expPix[i]) begin
        errors++; $display("[TB] FAIL addr_pix[%0d] got=%h want=%h", i, obsPix[i], expPix[i]);
      end
    end
  endtask

  task automatic test_commit_midstream();
    int n = 20;
    int held = 1;
    for (int k = 0; k < 9; k++) writeCoeff(k, 8'($urandom));
    writeCoeff(9, 8'($urandom_range(0, 6)));
    clearStim();
    for (int i = 0; i < n; i++) addWindow(randWindow(), 2'd2);
    applyStimulus(5);
    checks++;
    if (obsPend[5] !== 1'b0) begin errors++; $display("[TB] FAIL mid_pend_before got=%b want=0", obsPend[5]); end
    for (int c = 6; c <= n + 4; c++) if (obsPend[c] !== 1'b1) held = 0;
    checks++;
    if (held != 1) begin errors++; $display("[TB] FAIL mid_pend_held got=0 want=1 through cycle %0d", n + 4); end
    checks++;
    if (obsPend[n + 5] !== 1'b0) begin errors++; $display("[TB] FAIL mid_pend_clear got=%b want=0", obsPend[n + 5]); end
    checks++;
    if (obsPix.size() != expPix.size()) begin errors++; $display("[TB] FAIL mid_count got=%0d want=%0d", obsPix.size(), expPix.size()); end
    for (int i = 0; i < obsPix.size() && i < expPix.size(); i++) begin
      checks++;
      if (obsPix[i] !== expPix[i] || obsCyc[i] != i + 4) begin
        errors++; $display("[TB] FAIL mid_old_pix[%0d] got=%h@%0d want=%h@%0d", i, obsPix[i], obsCyc[i], expPix[i], i + 4);
      end
    end
    activeC = shadowC;
    activeShift = shadowShift;
    clearStim();
    for (int i = 0; i < 8; i++) addWindow(randWindow(), 2'd2);
    applyStimulus(-1);
    for (int i = 0; i < obsPix.size() && i < expPix.size(); i++) begin
      checks++;
      if (obsPix[i] !== expPix[i]) begin
        errors++; $display("[TB] FAIL mid_new_pix[%0d] got=%h want=%h", i, obsPix[i], expPix[i]);
      end
    end
  endtask

  task automatic test_reset_in_flight();
    int seen = 0;
    logic [71:0] w;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pixData = randWindow(); mode = 2'd1; pixValid = 1'b1;
    end
    @(negedge clk);
    pixValid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    modelIdentity();
    checks++;
    if (outValid !== 1'b0 || outPix !== 8'h00 || pending !== 1'b0) begin
      errors++; $display("[TB] FAIL flight_reset got=%b/%h/%b want=0/00/0", outValid, outPix, pending);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (outValid) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("[TB] FAIL flight_drop got=%0d valids want=0", seen); end
    clearStim();
    w = randWindow(); w[39:32] = 8'h6D;
    addWindow(w, 2'd2);
    for (int i = 0; i < 5; i++) addWindow(randWindow(), 2'd2);
    applyStimulus(-1);
    checks++;
    if (obsPix.size() < 1 || obsPix[0] !== 8'h6D) begin errors++; $display("[TB] FAIL flight_identity got=%h want=6d", obsPix[0]); end
    for (int i = 0; i < obsPix.size() && i < expPix.size(); i++) begin
      checks++;
      if (obsPix[i] !== expPix[i]) begin
        errors++; $display("[TB] FAIL flight_pix[%0d] got=%h want=%h", i, obsPix[i], expPix[i]);
      end
    end
  endtask

  task automatic test_reset_priority();
    bit saw, settled;
    for (int k = 0; k < 9; k++) writeCoeff(k, 8'($urandom));
    commitIdle(saw, settled);
    @(negedge clk);
    rst = 1'b1; coeffWr = 1'b1; coeffAddr = 4'd4; coeffData = 8'h03; coeffCommit = 1'b1;
    @(negedge clk);
    rst = 1'b0; coeffWr = 1'b0; coeffCommit = 1'b0;
    modelIdentity();
    @(negedge clk);
    checks++;
    if (pending !== 1'b0) begin errors++; $display("[TB] FAIL prio_pending got=%b want=0", pending); end
    clearStim();
    for (int i = 0; i < 6; i++) addWindow(randWindow(), 2'd2);
    applyStimulus(-1);
    checks++;
    if (obsPix.size() != expPix.size()) begin errors++; $display("[TB] FAIL prio_count got=%0d want=%0d", obsPix.size(), expPix.size()); end
    for (int i = 0; i < obsPix.size() && i < expPix.size(); i++) begin
      checks++;
      if (obsPix[i] !== stimWin[i][39:32]) begin
        errors++; $display("[TB] FAIL prio_pix[%0d] got=%h want=%h", i, obsPix[i], stimWin[i][39:32]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    pixData = 72'h0; pixValid = 1'b0; mode = 2'd0;
    coeffWr = 1'b0; coeffAddr = 4'd0; coeffData = 8'h00; coeffCommit = 1'b0;
    modelIdentity();
    test_reset();
    test_box_blur();
    test_bypass();
    test_custom_kernel();
    test_random_custom();
    test_address_ignore();
    test_commit_midstream();
    test_reset_in_flight();
    test_reset_priority();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/configurable_convolution.md
CONFIGURABLE_CONVOLUTION -- requirements
Module: configurable_convolution

Interface
REQ-001 Parameter PIX_W, default 8, packed pixel width; R_W/G_W/B_W (defaults 3/3/2) SHALL sum to PIX_W, with R in the MSBs and B in the LSBs.
REQ-002 Parameter COEFF_W, default 8, signed two's-complement coefficient width.
REQ-003 Parameter SHIFT_W, default 4, width of the normalisation shift.
REQ-004 Clock is i_clock; reset is i_reset, synchronous, active-high.
REQ-005 Ports: i_clock in 1; i_reset in 1; i_pixel_data in 9*PIX_W, 3x3 window, tap k at [PIX_W*k +: PIX_W], k=4 centre, row-major; i_pixel_data_valid in 1.
REQ-006 Mode port: i_mode in 2; 0 = bypass centre, 1 = box blur, 2 = custom kernel, 3 = reserved and treated as 0.
REQ-007 Coefficient ports: i_coeff_wr in 1; i_coeff_addr in 4, taps 0-8, with 9 addressing the shift; i_coeff_data in COEFF_W; i_coeff_commit in 1.
REQ-008 Outputs: o_convoled_pixel out PIX_W; o_convoled_pixel_valid out 1; o_commit_pending out 1.

Function
REQ-009 Pipeline SHALL be 4 stages: (1) unpack R/G/B and register mode, (2) multiply, (3) per-channel sum, (4) normalise, clamp and pack. Valid-in to valid-out latency is exactly 4 cycles; no stalls; full throughput of one window per cycle.
REQ-010 Channels SHALL be processed at native width, right-aligned and zero-extended, not left-aligned.
REQ-011 Mode is sampled with the pixel at stage 1 and travels with it down the pipeline.
REQ-012 Mode 0: the output SHALL equal centre tap k=4 unchanged.
REQ-013 Mode 1: each channel output SHALL be floor(sum of 9 taps / 9), exact integer division, with coefficients ignored.
REQ-014 Mode 2: each channel SHALL compute the signed sum of coeff[k]*tap[k], then arithmetic right shift by the active shift, then clamp to [0, 2^ch_w-1].
REQ-015 Product width SHALL be COEFF_W+ch_w+1 signed; sum width SHALL be product width+4; no intermediate overflow is permitted.
REQ-016 A write (i_coeff_wr) SHALL update only the shadow register at i_coeff_addr; addresses 10-15 are ignored.
REQ-017 Shift writes SHALL use the low SHIFT_W bits of i_coeff_data.
REQ-018 Commit SHALL set a pending flag; the shadow set (taps and shift) is copied to the active set on the first cycle with no valid in stages 1-4 and i_pixel_data_valid low.
REQ-019 The pending flag SHALL clear in the same cycle as the copy; o_commit_pending reflects the flag.
REQ-020 A commit while pending is already set SHALL be a no-op; the copy SHALL use the shadow contents at copy time.
REQ-021 A write and a commit in the same cycle: the write lands in the shadow first, and the copy includes it.
REQ-022 Every window SHALL use one consistent active set; windows accepted before the copy use the old set.
REQ-023 Outputs SHALL change only with valid; o_convoled_pixel holds its last value while o_convoled_pixel_valid is low.

Reset
REQ-024 i_reset SHALL clear all pipeline valids and drop in-flight windows; o_convoled_pixel_valid is 0 in the cycle after reset is sampled.
REQ-025 o_convoled_pixel and o_commit_pending SHALL reset to 0.
REQ-026 Active and shadow sets SHALL reset to identity (coeff[4]=1, others 0, shift 0).
REQ-027 Reset SHALL take priority over a write or commit in the same cycle.

Structure
REQ-028 Package conv_pkg SHALL hold: mode encodings, tap count 9, centre index 4, shift address 9, and default channel widths.
REQ-029 One sub-module, conv_coeff_bank, SHALL hold the shadow/active registers, the write/commit logic and the pending flag; the datapath stays in configurable_convolution.

Verification
REQ-030 Reset; mode 1, all taps 8'hFF, one valid cycle -> 8'hFF exactly 4 cycles later, valid high for 1 cycle.
REQ-031 Mode 1, centre 8'hE0, others 8'h00 -> 8'h00 (R 7/9=0).
REQ-032 Load coeff 4=5, coeff 1/3/5/7=-1, others 0, shift 0, commit:
- all taps 8'h49 -> 8'h49;
- centre 8'hFF, others 0 -> 8'hFF (clamp high);
- centre 0, others 8'hFF -> 8'h00 (clamp low).
REQ-033 Continuous valid stream in mode 2 with commit mid-stream -> o_commit_pending stays 1 until valid drops and 4 idle cycles pass; all pixels before the gap use the old set.
REQ-034 Mode 0, centre 8'h6D, others random -> 8'h6D; mode 3 gives the same result.
REQ-035 Assert i_reset with 3 windows in flight -> no valid output follows; then mode 2, centre 8'h6D -> 8'h6D (identity set).
